// File: rtl/pic_ack_sequencer.sv
// pic_ack_sequencer: CPU-side interrupt acknowledge engine for the pic block.
// Synchronises pic_int, pulses intack, reads the vector, hands it to the core
// over valid/ready and writes a non-specific EOI back to the pic on request.
// Optional feature macro: PIC_SPURIOUS_CHECK_EN (recheck int on the last ACK
// cycle, report SPUR_VEC and a 'spurious' flag, skip READ and EOI).

`ifndef SEL_OCR
`define SEL_OCR 2'b10
`endif
`ifndef RW_READ
`define RW_READ 1'b1
`endif
`ifndef RW_WRITE
`define RW_WRITE 1'b0
`endif

module pic_ack_sequencer #(
    parameter int unsigned ACK_CYCLES = 2,          // intack width, 1..15
    parameter logic [1:0]  VEC_SEL    = 2'b01,
    parameter logic [1:0]  EOI_SEL    = `SEL_OCR,
    parameter logic [7:0]  EOI_CMD    = 8'h20
`ifdef PIC_SPURIOUS_CHECK_EN
    ,
    parameter logic [7:0]  SPUR_VEC   = 8'h07
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pic_int,
    input  logic [7:0] pic_data_in,
    output logic [7:0] pic_data_out,
    output logic       pic_data_oe,
    output logic [1:0] pic_select,
    output logic       pic_readwrite,
    output logic       pic_intack,
    input  logic       cpu_ie,
    output logic       irq_pending,
    output logic       vec_valid,
    output logic [7:0] vec,
    input  logic       vec_ready,
    input  logic       eoi_req,
`ifdef PIC_SPURIOUS_CHECK_EN
    output logic       spurious,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_READ,
        S_PRESENT,
        S_SERVICE,
        S_EOI
    } state_t;

    localparam logic [3:0] ACK_LAST = 4'(ACK_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic       int_meta;
    logic       int_s;
    logic [3:0] ack_cnt;
    logic       ack_last;

    // Two-flop synchroniser for the asynchronous pic interrupt line.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_meta <= 1'b0;
            int_s    <= 1'b0;
        end else begin
            int_meta <= pic_int;
            int_s    <= int_meta;
        end
    end

    // State register; reset aborts any sequence immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts cycles spent in ACK; cleared whenever ACK is left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_cnt <= 4'd0;
        end else if (state == S_ACK) begin
            ack_cnt <= ack_cnt + 4'd1;
        end else begin
            ack_cnt <= 4'd0;
        end
    end

    assign ack_last = (state == S_ACK) && (ack_cnt == ACK_LAST);

`ifdef PIC_SPURIOUS_CHECK_EN
    logic spur_q;

    // Vector capture: bus value at the end of READ, or SPUR_VEC if int vanished.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec <= 8'h00;
        end else if (state == S_READ) begin
            vec <= pic_data_in;
        end else if (ack_last && !int_s) begin
            vec <= SPUR_VEC;
        end
    end

    // Spurious flag decided on the last ACK cycle, held through PRESENT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spur_q <= 1'b0;
        end else if (ack_last) begin
            spur_q <= !int_s;
        end
    end

    assign spurious = spur_q && (state == S_PRESENT);
`else
    // Vector capture: bus value sampled at the end of the READ cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec <= 8'h00;
        end else if (state == S_READ) begin
            vec <= pic_data_in;
        end
    end
`endif

    // Next-state and pic bus outputs, all decoded from the current state.
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        pic_select    = `SEL_OCR;
        pic_readwrite = `RW_READ;
        pic_data_out  = 8'h00;
        pic_data_oe   = 1'b0;
        pic_intack    = 1'b0;
        vec_valid     = 1'b0;

        case (state)
            S_IDLE: begin
                // A pending EOI beats a new acknowledge; the ACK follows later.
                if (eoi_req) begin
                    state_next = S_EOI;
                end else if (int_s && cpu_ie) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                pic_intack = 1'b1;
                if (ack_last) begin
`ifdef PIC_SPURIOUS_CHECK_EN
                    state_next = int_s ? S_READ : S_PRESENT;
`else
                    state_next = S_READ;
`endif
                end
            end
            S_READ: begin
                pic_select = VEC_SEL;
                state_next = S_PRESENT;
            end
            S_PRESENT: begin
                vec_valid = 1'b1;
                if (vec_ready) begin
`ifdef PIC_SPURIOUS_CHECK_EN
                    state_next = spur_q ? S_IDLE : S_SERVICE;
`else
                    state_next = S_SERVICE;
`endif
                end
            end
            S_SERVICE: begin
                if (eoi_req) begin
                    state_next = S_EOI;
                end
            end
            S_EOI: begin
                pic_select    = EOI_SEL;
                pic_readwrite = `RW_WRITE;
                pic_data_out  = EOI_CMD;
                pic_data_oe   = 1'b1;
                state_next    = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign irq_pending = int_s && (state == S_IDLE);

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Testbench for pic_ack_sequencer: randomized transactions checked against a
// cycle-timeline model derived from the acknowledge sequence rules.

`ifndef SEL_OCR
`define SEL_OCR 2'b10
`endif
`ifndef RW_READ
`define RW_READ 1'b1
`endif
`ifndef RW_WRITE
`define RW_WRITE 1'b0
`endif

module tb_pic_ack_sequencer;

    localparam int         ACK      = 2;
    localparam logic [1:0] VEC_SEL  = 2'b01;
    localparam logic [1:0] SEL_OCR  = `SEL_OCR;
    localparam logic [1:0] EOI_SEL  = `SEL_OCR;
    localparam logic       RW_READ  = `RW_READ;
    localparam logic       RW_WRITE = `RW_WRITE;
    localparam logic [7:0] EOI_CMD  = 8'h20;
    localparam logic [7:0] SPUR_VEC = 8'h07;
`ifdef PIC_SPURIOUS_CHECK_EN
    localparam bit SPUR_EN = 1'b1;
`else
    localparam bit SPUR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pic_int;
    logic [7:0] pic_data_in;
    logic [7:0] pic_data_out;
    logic       pic_data_oe;
    logic [1:0] pic_select;
    logic       pic_readwrite;
    logic       pic_intack;
    logic       cpu_ie;
    logic       irq_pending;
    logic       vec_valid;
    logic [7:0] vec;
    logic       vec_ready;
    logic       eoi_req;
    logic       busy;
`ifdef PIC_SPURIOUS_CHECK_EN
    logic       spurious;
`endif

    int checks = 0;
    int errors = 0;

    pic_ack_sequencer #(.ACK_CYCLES(ACK)) dut (
        .clk           (clk),
        .reset         (reset),
        .pic_int       (pic_int),
        .pic_data_in   (pic_data_in),
        .pic_data_out  (pic_data_out),
        .pic_data_oe   (pic_data_oe),
        .pic_select    (pic_select),
        .pic_readwrite (pic_readwrite),
        .pic_intack    (pic_intack),
        .cpu_ie        (cpu_ie),
        .irq_pending   (irq_pending),
        .vec_valid     (vec_valid),
        .vec           (vec),
        .vec_ready     (vec_ready),
        .eoi_req       (eoi_req),
`ifdef PIC_SPURIOUS_CHECK_EN
        .spurious      (spurious),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] obs_bus();
        return {pic_data_out, pic_data_oe, pic_select, pic_readwrite,
                pic_intack, irq_pending, vec_valid, busy};
    endfunction

    function automatic logic [15:0] mk_bus(logic [7:0] d, logic oe, logic [1:0] sel,
                                           logic rw, logic ia, logic irq, logic vv, logic bz);
        return {d, oe, sel, rw, ia, irq, vv, bz};
    endfunction

    function automatic logic [15:0] idle_bus(logic irq);
        return mk_bus(8'h00, 1'b0, SEL_OCR, RW_READ, 1'b0, irq, 1'b0, 1'b0);
    endfunction

    function automatic logic [15:0] eoi_bus();
        return mk_bus(EOI_CMD, 1'b1, EOI_SEL, RW_WRITE, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // One full transaction from IDLE. Cycle c is observed 1 ns after posedge c;
    // inputs set in cycle c are seen by the DUT at posedge c+1.
    // pic_int is high for cycles 0..drop-1, so int_s is high for cycles 2..drop+1.
    task automatic run_txn(input string name, input logic [7:0] v, input int drop,
                           input int rdy_dly, input int eoi_dly, input bit noise);
        bit spur;
        int vv_start, hs, eoi_c, end_c;
        logic exp_ia, exp_rd, exp_eo, exp_vv, exp_bz, exp_irq;
        logic [15:0] exp, obs;
        // int_s on the last ACK cycle (ACK+2) mirrors pic_int at cycle ACK.
        spur     = SPUR_EN && (drop <= ACK);
        vv_start = spur ? ACK + 3 : ACK + 4;
        hs       = vv_start + rdy_dly + 1;
        eoi_c    = spur ? -1 : hs + eoi_dly + 1;
        end_c    = spur ? hs : eoi_c + 1;

        pic_int     = 1'b1;
        cpu_ie      = 1'b1;
        vec_ready   = 1'b0;
        eoi_req     = 1'b0;
        pic_data_in = 8'($urandom);
        for (int c = 1; c <= end_c + 1; c++) begin
            tick();
            exp_ia  = (c >= 3) && (c <= ACK + 2);
            exp_rd  = !spur && (c == ACK + 3);
            exp_eo  = !spur && (c == eoi_c);
            exp_vv  = (c >= vv_start) && (c < hs);
            exp_bz  = (c >= 3) && (c < end_c);
            exp_irq = !exp_bz && (c >= 2) && (c - 2 < drop);
            exp = mk_bus(exp_eo ? EOI_CMD : 8'h00, exp_eo,
                         exp_rd ? VEC_SEL : (exp_eo ? EOI_SEL : SEL_OCR),
                         exp_eo ? RW_WRITE : RW_READ,
                         exp_ia, exp_irq, exp_vv, exp_bz);
            obs = obs_bus();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s bus cyc %0d: got %h want %h", name, c, obs, exp);
            end
            if (exp_vv) begin
                checks++;
                if (vec !== (spur ? SPUR_VEC : v)) begin
                    errors++;
                    $display("FAIL %s vec cyc %0d: got %h want %h", name, c, vec,
                             spur ? SPUR_VEC : v);
                end
            end
`ifdef PIC_SPURIOUS_CHECK_EN
            checks++;
            if (spurious !== (exp_vv && spur)) begin
                errors++;
                $display("FAIL %s spurious cyc %0d: got %b want %b", name, c, spurious,
                         exp_vv && spur);
            end
`endif
            // Drive inputs for the next edge.
            pic_int     = (c < drop);
            pic_data_in = (!spur && c == ACK + 3) ? v : 8'($urandom);
            if (c == vv_start + rdy_dly)
                vec_ready = 1'b1;
            else if (noise && c < vv_start)
                vec_ready = 1'($urandom);
            else
                vec_ready = 1'b0;
            if (!spur && c == hs + eoi_dly)
                eoi_req = 1'b1;
            else if (noise && c >= 3 && c <= hs - 1)
                eoi_req = 1'($urandom);
            else
                eoi_req = 1'b0;
            cpu_ie = (noise && c >= 3) ? 1'($urandom) : 1'b1;
        end
        pic_int   = 1'b0;
        vec_ready = 1'b0;
        eoi_req   = 1'b0;
        cpu_ie    = 1'b1;
    endtask

    // Completes a sequence already under way: waits for the vector, accepts it,
    // requests EOI and expects the idle bus afterwards.
    task automatic finish_seq(input string name, input logic [7:0] v);
        int n = 0;
        logic [15:0] obs;
        while (!vec_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!vec_valid) begin
            errors++;
            $display("FAIL %s vec_valid timeout: got 0 want 1", name);
        end else if (vec !== v) begin
            errors++;
            $display("FAIL %s vec: got %h want %h", name, vec, v);
        end
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        obs = obs_bus();
        checks++;
        if (obs !== mk_bus(8'h00, 1'b0, SEL_OCR, RW_READ, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL %s service: got %h want %h", name, obs,
                     mk_bus(8'h00, 1'b0, SEL_OCR, RW_READ, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        eoi_req = 1'b1;
        tick();
        eoi_req = 1'b0;
        obs = obs_bus();
        checks++;
        if (obs !== eoi_bus()) begin
            errors++;
            $display("FAIL %s eoi: got %h want %h", name, obs, eoi_bus());
        end
        tick();
        obs = obs_bus();
        checks++;
        if (obs !== idle_bus(1'b0)) begin
            errors++;
            $display("FAIL %s idle: got %h want %h", name, obs, idle_bus(1'b0));
        end
    endtask

    task automatic test_reset();
        logic [23:0] obs;
        reset       = 1'b1;
        pic_int     = 1'b0;
        cpu_ie      = 1'b0;
        pic_data_in = 8'h00;
        vec_ready   = 1'b0;
        eoi_req     = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (i == 3) reset = 1'b0;
            tick();
            obs = {obs_bus(), vec};
            checks++;
            if (obs !== {idle_bus(1'b0), 8'h00}) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h want %h", i, obs, {idle_bus(1'b0), 8'h00});
            end
        end
    endtask

    task automatic test_basic();
        run_txn("basic", 8'h4A, ACK + 3, 3, 2, 1'b0);
    endtask

    task automatic test_cpu_ie_gate();
        logic [15:0] obs;
        cpu_ie      = 1'b0;
        pic_int     = 1'b1;
        pic_data_in = 8'h91;
        for (int c = 1; c <= 6; c++) begin
            tick();
            obs = obs_bus();
            checks++;
            if (obs !== idle_bus(c >= 2)) begin
                errors++;
                $display("FAIL ie_gate wait cyc %0d: got %h want %h", c, obs, idle_bus(c >= 2));
            end
        end
        cpu_ie = 1'b1;
        tick();
        obs = obs_bus();
        checks++;
        if (obs !== mk_bus(8'h00, 1'b0, SEL_OCR, RW_READ, 1'b1, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL ie_gate start: got %h want %h", obs,
                     mk_bus(8'h00, 1'b0, SEL_OCR, RW_READ, 1'b1, 1'b0, 1'b0, 1'b1));
        end
        pic_int = 1'b0;
        cpu_ie  = 1'b0;   // dropping enable mid-sequence must not abort it
        finish_seq("ie_gate", 8'h91);
        cpu_ie = 1'b1;
    endtask

    task automatic test_eoi_idle();
        logic [15:0] obs;
        eoi_req = 1'b1;
        tick();
        eoi_req = 1'b0;
        obs = obs_bus();
        checks++;
        if (obs !== eoi_bus()) begin
            errors++;
            $display("FAIL eoi_idle eoi: got %h want %h", obs, eoi_bus());
        end
        tick();
        obs = obs_bus();
        checks++;
        if (obs !== idle_bus(1'b0)) begin
            errors++;
            $display("FAIL eoi_idle back: got %h want %h", obs, idle_bus(1'b0));
        end
        // EOI and a new interrupt together: EOI first, then ACK from IDLE.
        pic_int     = 1'b1;
        cpu_ie      = 1'b1;
        pic_data_in = 8'h3C;
        tick();
        tick();
        obs = obs_bus();
        checks++;
        if (obs !== idle_bus(1'b1)) begin
            errors++;
            $display("FAIL eoi_race pending: got %h want %h", obs, idle_bus(1'b1));
        end
        eoi_req = 1'b1;
        tick();
        eoi_req = 1'b0;
        obs = obs_bus();
        checks++;
        if (obs !== eoi_bus()) begin
            errors++;
            $display("FAIL eoi_race eoi: got %h want %h", obs, eoi_bus());
        end
        tick();
        obs = obs_bus();
        checks++;
        if (obs !== idle_bus(1'b1)) begin
            errors++;
            $display("FAIL eoi_race idle: got %h want %h", obs, idle_bus(1'b1));
        end
        tick();
        obs = obs_bus();
        checks++;
        if (obs !== mk_bus(8'h00, 1'b0, SEL_OCR, RW_READ, 1'b1, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL eoi_race ack: got %h want %h", obs,
                     mk_bus(8'h00, 1'b0, SEL_OCR, RW_READ, 1'b1, 1'b0, 1'b0, 1'b1));
        end
        pic_int = 1'b0;
        finish_seq("eoi_race", 8'h3C);
    endtask

    task automatic test_reset_mid();
        logic [2:0] obs;
        pic_int = 1'b1;
        cpu_ie  = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        checks++;
        if (pic_intack !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid intack before: got %b want 1", pic_intack);
        end
        #2;
        reset   = 1'b1;
        pic_int = 1'b0;
        #1;
        obs = {pic_intack, busy, vec_valid};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid async: got %b want 000", obs);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            obs = {pic_intack, busy, vec_valid};
            checks++;
            if (obs !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid after cyc %0d: got %b want 000", c, obs);
            end
        end
    endtask

    task automatic test_spurious();
`ifdef PIC_SPURIOUS_CHECK_EN
        run_txn("spurious", 8'($urandom), 1, 2, 0, 1'b0);
        run_txn("after_spur", 8'hC3, ACK + 3, 1, 1, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        logic [15:0] obs;
        for (int i = 0; i < 10; i++) begin
            run_txn("random", 8'($urandom), int'($urandom_range(ACK + 3, 1)),
                    int'($urandom_range(4, 0)), int'($urandom_range(3, 0)), 1'b1);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                tick();
                obs = obs_bus();
                checks++;
                if (obs !== idle_bus(1'b0)) begin
                    errors++;
                    $display("FAIL gap %0d: got %h want %h", i, obs, idle_bus(1'b0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cpu_ie_gate();
        test_eoi_idle();
        test_reset_mid();
        test_spurious();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
